// File: rtl/mrd_pkg.sv
// Shared definitions for the MR-descent column sequencer: FSM encoding and
// elaboration-time helpers for index width, fixed-point one and iteration total.
package mrd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ITER = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Minimum of 1 bit so a single-entry range still has a usable index.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int one_of(input int frac);
    return 1 << frac;
  endfunction

  function automatic int iter_total(input int iter_num, input int iter_lat);
    return iter_num * iter_lat;
  endfunction

endpackage

// File: rtl/mrd_unit_vec_gen.sv
// Builds a DIMENSION-element vector holding val_i in element sel_i and zeros elsewhere.
module mrd_unit_vec_gen #(
  parameter int DIMENSION = 16,
  parameter int WIDTH     = 8,
  parameter int IDX_W     = 4
) (
  input  logic [IDX_W-1:0]           sel_i,
  input  logic signed [WIDTH-1:0]    val_i,
  output logic [DIMENSION*WIDTH-1:0] vec_o
);

  always_comb begin
    vec_o = '0;
    for (int k = 0; k < DIMENSION; k++) begin
      if (sel_i == IDX_W'(k)) vec_o[k*WIDTH +: WIDTH] = val_i;
    end
  end

endmodule

// File: rtl/mrd_col_sequencer.sv
// Column sequencer for the MR-descent inverse core: walks j, drives ej/M_init,
// runs the core for ITER_NUM iterations and streams each captured column out.
module mrd_col_sequencer
  import mrd_pkg::*;
#(
  parameter int DIMENSION = 16,
  parameter int WIDTH     = 8,
  parameter int ITER_NUM  = 2,
  parameter int ITER_LAT  = 4,
  parameter int FRAC      = 4,
  localparam int IDX_W    = clog2(DIMENSION)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic signed [WIDTH-1:0]     init_scale,
  output logic                        core_en,
  output logic                        core_load,
  output logic [DIMENSION*WIDTH-1:0]  ej,
  output logic [DIMENSION*WIDTH-1:0]  M_init,
  input  logic [DIMENSION*WIDTH-1:0]  M_iter,
  output logic                        col_valid,
  input  logic                        col_ready,
  output logic [IDX_W-1:0]            col_idx,
  output logic [DIMENSION*WIDTH-1:0]  col_data,
  output logic                        busy,
  output logic                        done
);

  localparam int ITER_TOTAL = iter_total(ITER_NUM, ITER_LAT);
  localparam int CNT_W      = clog2(ITER_TOTAL);
  localparam logic signed [WIDTH-1:0] ONE_W = WIDTH'(one_of(FRAC));

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           j_q, j_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       capture;
  logic                       core_en_q, core_load_q, col_valid_q, busy_q, done_q;
  logic [IDX_W-1:0]           col_idx_q;
  logic [DIMENSION*WIDTH-1:0] col_data_q, ej_q, m_init_q, ej_w, m_init_w;

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_LOAD;
        j_d     = '0;
      end
      ST_LOAD: begin
        state_d = ST_ITER;
        cnt_d   = '0;
      end
      ST_ITER: begin
        if (cnt_q == CNT_W'(ITER_TOTAL - 1)) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = ST_OUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_OUT: if (col_valid_q && col_ready) begin
        if (j_q == IDX_W'(DIMENSION - 1)) begin
          state_d = ST_DONE;
        end else begin
          j_d     = j_q + IDX_W'(1);
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        j_d     = '0;
      end
      default: begin
        state_d = ST_IDLE;
        j_d     = '0;
      end
    endcase
    // abort wins over any handshake or capture in the same cycle
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      j_d     = '0;
      cnt_d   = '0;
      capture = 1'b0;
    end
  end

  // Vectors are built from the next column index so they are valid in the LOAD cycle.
  mrd_unit_vec_gen #(.DIMENSION(DIMENSION), .WIDTH(WIDTH), .IDX_W(IDX_W)) u_ej_gen (
    .sel_i (j_d),
    .val_i (ONE_W),
    .vec_o (ej_w)
  );

  mrd_unit_vec_gen #(.DIMENSION(DIMENSION), .WIDTH(WIDTH), .IDX_W(IDX_W)) u_minit_gen (
    .sel_i (j_d),
    .val_i (init_scale),
    .vec_o (m_init_w)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      j_q         <= '0;
      cnt_q       <= '0;
      core_en_q   <= 1'b0;
      core_load_q <= 1'b0;
      col_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      col_idx_q   <= '0;
      col_data_q  <= '0;
      ej_q        <= '0;
      m_init_q    <= '0;
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      cnt_q       <= cnt_d;
      core_en_q   <= (state_d == ST_LOAD) || (state_d == ST_ITER);
      core_load_q <= (state_d == ST_LOAD);
      col_valid_q <= (state_d == ST_OUT);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
      if (state_d == ST_LOAD) begin
        ej_q     <= ej_w;
        m_init_q <= m_init_w;
      end
      if (capture) begin
        col_data_q <= M_iter;
        col_idx_q  <= j_q;
      end
    end
  end

  assign core_en   = core_en_q;
  assign core_load = core_load_q;
  assign col_valid = col_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign col_idx   = col_idx_q;
  assign col_data  = col_data_q;
  assign ej        = ej_q;
  assign M_init    = m_init_q;

endmodule

// File: tb/tb_mrd_col_sequencer.sv
// Directed bench for mrd_col_sequencer: reset, full sweeps, backpressure, abort,
// ignored start and a second instance with longer iteration settings.
module tb_mrd_col_sequencer;

  localparam int D  = 16;
  localparam int W  = 8;
  localparam int VW = D * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, start, abort, col_ready;
  logic signed [W-1:0] init_scale;
  logic                core_en, core_load, col_valid, busy, done;
  logic [3:0]          col_idx;
  logic [VW-1:0]       ej, m_init, m_iter, col_data;

  logic                start6, abort6, col_ready6;
  logic signed [W-1:0] init_scale6;
  logic                core_en6, core_load6, col_valid6, busy6, done6;
  logic [3:0]          col_idx6;
  logic [VW-1:0]       ej6, m_init6, m_iter6, col_data6;

  mrd_col_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .init_scale(init_scale),
    .core_en(core_en), .core_load(core_load), .ej(ej), .M_init(m_init), .M_iter(m_iter),
    .col_valid(col_valid), .col_ready(col_ready), .col_idx(col_idx), .col_data(col_data),
    .busy(busy), .done(done)
  );

  mrd_col_sequencer #(.ITER_NUM(3), .ITER_LAT(5)) u_dut6 (
    .clk(clk), .rst(rst), .start(start6), .abort(abort6), .init_scale(init_scale6),
    .core_en(core_en6), .core_load(core_load6), .ej(ej6), .M_init(m_init6), .M_iter(m_iter6),
    .col_valid(col_valid6), .col_ready(col_ready6), .col_idx(col_idx6), .col_data(col_data6),
    .busy(busy6), .done(done6)
  );

  // Core stand-in: result is the unit vector doubled.
  always_comb begin
    m_iter  = '0;
    m_iter6 = '0;
    for (int k = 0; k < D; k++) begin
      m_iter[k*W +: W]  = ej[k*W +: W] << 1;
      m_iter6[k*W +: W] = ej6[k*W +: W] << 1;
    end
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [VW-1:0] unit(input int j, input logic [W-1:0] v);
    logic [VW-1:0] r;
    r = '0;
    r[j*W +: W] = v;
    return r;
  endfunction

  task automatic check_zero(input string tag);
    check_eq({tag, "_core_en"},   core_en,   0);
    check_eq({tag, "_core_load"}, core_load, 0);
    check_eq({tag, "_col_valid"}, col_valid, 0);
    check_eq({tag, "_col_idx"},   col_idx,   0);
    check_eq({tag, "_col_data"},  col_data,  0);
    check_eq({tag, "_busy"},      busy,      0);
    check_eq({tag, "_done"},      done,      0);
    check_eq({tag, "_ej"},        ej,        0);
    check_eq({tag, "_m_init"},    m_init,    0);
  endtask

  task automatic run_sweep(input string tag, input int p1, input int p2);
    int nhs, first_v, last_hs, ndone, done_cyc;
    nhs = 0; first_v = 0; last_hs = 0; ndone = 0; done_cyc = 0;
    col_ready  = 1'b1;
    init_scale = 8'sd8;
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
    while (cyc < 170) begin
      if (cyc == 1) begin
        check_eq({tag, "_load_c1"},  core_load, 1);
        check_eq({tag, "_ej_c1"},    ej,        unit(0, 8'h10));
        check_eq({tag, "_minit_c1"}, m_init,    unit(0, 8'h08));
      end
      if (cyc == 2) check_eq({tag, "_load_c2"}, core_load, 0);
      if (col_valid && first_v == 0) first_v = cyc;
      if (col_valid && col_ready) begin
        check_eq({tag, "_idx"},  col_idx,  nhs);
        check_eq({tag, "_data"}, col_data, unit(nhs, 8'h20));
        nhs++;
        last_hs = cyc;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
        check_eq({tag, "_busy_in_done"}, busy, 1);
      end
      start = (cyc == p1) || (cyc == p2);
      tick();
    end
    start = 1'b0;
    check_eq({tag, "_first_valid"}, first_v,  10);
    check_eq({tag, "_last_hs"},     last_hs,  160);
    check_eq({tag, "_done_cyc"},    done_cyc, 161);
    check_eq({tag, "_done_cnt"},    ndone,    1);
    check_eq({tag, "_hs_cnt"},      nhs,      16);
    check_eq({tag, "_busy_end"},    busy,     0);
  endtask

  initial begin
    int nv, fv, bad;
    rst = 1'b0; start = 1'b0; abort = 1'b0; col_ready = 1'b1; init_scale = 8'sd8;
    start6 = 1'b0; abort6 = 1'b0; col_ready6 = 1'b1; init_scale6 = 8'sd8;
    tick();
    tick();
    check_zero("por");
    rst = 1'b1;
    tick();

    // Reset mid-ITER of column 5
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
    while (cyc < 55) tick();
    check_eq("pre_rst_core_en", core_en, 1);
    check_eq("pre_rst_idx",     col_idx, 4);
    check_eq("pre_rst_ej",      ej,      unit(5, 8'h10));
    #2 rst = 1'b0;
    #1 check_zero("async_rst");
    tick();
    rst = 1'b1;
    tick();
    check_eq("post_rst_busy",  busy,      0);
    check_eq("post_rst_valid", col_valid, 0);
    check_eq("post_rst_en",    core_en,   0);

    run_sweep("sweep", -1, -1);
    run_sweep("busy_start", 3, 50);

    // Backpressure on column 3, then abort in ITER of column 9
    col_ready = 1'b1;
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
    for (int g = 0; g < 60 && !(col_valid && col_idx == 4'd3); g++) tick();
    check_eq("bp_reach_cyc", cyc, 40);
    col_ready = 1'b0;
    for (int s = 0; s < 7; s++) begin
      check_eq("bp_idx",   col_idx,   3);
      check_eq("bp_data",  col_data,  unit(3, 8'h20));
      check_eq("bp_en",    core_en,   0);
      check_eq("bp_valid", col_valid, 1);
      tick();
    end
    col_ready = 1'b1;
    check_eq("bp_valid_hs", col_valid, 1);
    tick();
    check_eq("bp_load_next", core_load, 1);
    check_eq("bp_ej_next",   ej,        unit(4, 8'h10));

    for (int g = 0; g < 120 && !(core_en && !core_load && ej == unit(9, 8'h10)); g++) tick();
    check_eq("ab_reach_iter9", core_en && !core_load && (ej == unit(9, 8'h10)), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("ab_iter_valid", col_valid, 0);
    check_eq("ab_iter_en",    core_en,   0);
    check_eq("ab_iter_busy",  busy,      0);
    check_eq("ab_iter_done",  done,      0);
    nv = 0;
    for (int g = 0; g < 20; g++) begin
      if (col_valid || done) nv++;
      tick();
    end
    check_eq("ab_iter_quiet", nv, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("restart_load", core_load, 1);
    check_eq("restart_ej",   ej,        unit(0, 8'h10));
    for (int g = 0; g < 20 && !col_valid; g++) tick();
    check_eq("ab_out_valid_pre", col_valid, 1);
    check_eq("ab_out_idx_pre",   col_idx,   0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("ab_out_valid", col_valid, 0);
    check_eq("ab_out_en",    core_en,   0);
    check_eq("ab_out_busy",  busy,      0);
    check_eq("ab_out_done",  done,      0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("restart2_load", core_load, 1);
    check_eq("restart2_ej",   ej,        unit(0, 8'h10));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("restart2_abort_busy", busy, 0);

    // Longer iteration settings on the second instance
    start6 = 1'b1;
    cyc    = 0;
    tick();
    start6 = 1'b0;
    fv  = 0;
    bad = 0;
    while (cyc <= 40) begin
      if (col_valid6 && fv == 0) fv = cyc;
      if (core_load6 !== ((cyc == 1) || (cyc == 18) || (cyc == 35))) bad++;
      tick();
    end
    check_eq("p6_first_valid", fv,        17);
    check_eq("p6_load_cycles", bad,       0);
    check_eq("p6_idx",         col_idx6,  1);
    check_eq("p6_data",        col_data6, unit(1, 8'h20));
    abort6 = 1'b1;
    tick();
    abort6 = 1'b0;
    check_eq("p6_abort_busy", busy6, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
